axi_light_arbiter: RTL and testbench



---
 rtl/axi_light_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_axi_light_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_light_arbiter.sv
// Round-robin arbiter sharing one AXI-light slave port among NUM_M masters, one transaction at a time.
// Optional per-master completion counters on txn_count when AXI_ARB_STATS_EN is defined.
module axi_light_arbiter #(
   parameter  int NUM_M  = 2,
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic                      clk,
   input  logic                      res_n,
   input  logic [NUM_M-1:0]          s_awvalid,
   output logic [NUM_M-1:0]          s_awready,
   input  logic [NUM_M*ADDR_W-1:0]   s_awaddr,
   input  logic [NUM_M-1:0]          s_wvalid,
   output logic [NUM_M-1:0]          s_wready,
   input  logic [NUM_M*DATA_W-1:0]   s_wdata,
   input  logic [NUM_M*STRB_W-1:0]   s_wstrb,
   output logic [NUM_M-1:0]          s_bvalid,
   input  logic [NUM_M-1:0]          s_bready,
   input  logic [NUM_M-1:0]          s_arvalid,
   output logic [NUM_M-1:0]          s_arready,
   input  logic [NUM_M*ADDR_W-1:0]   s_araddr,
   output logic [NUM_M-1:0]          s_rvalid,
   input  logic [NUM_M-1:0]          s_rready,
   output logic [DATA_W-1:0]         s_rdata,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [ADDR_W-1:0]         m_awaddr,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   output logic [DATA_W-1:0]         m_wdata,
   output logic [STRB_W-1:0]         m_wstrb,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   output logic                      m_arvalid,
   input  logic                      m_arready,
   output logic [ADDR_W-1:0]         m_araddr,
   input  logic                      m_rvalid,
   output logic                      m_rready,
   input  logic [DATA_W-1:0]         m_rdata,
   output logic [NUM_M-1:0]          grant,
`ifdef AXI_ARB_STATS_EN
   output logic [NUM_M*16-1:0]       txn_count,
`endif
   output logic                      busy
);

   localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WADDR = 3'd1;
   localparam logic [2:0] WRESP = 3'd2;
   localparam logic [2:0] RADDR = 3'd3;
   localparam logic [2:0] RRESP = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [NUM_M-1:0] grant_q, grant_d;
   logic [PTR_W-1:0] rr_q, rr_d;
   logic             aw_done_q, aw_done_d, w_done_q, w_done_d;

   logic [NUM_M-1:0] req;
   logic [PTR_W-1:0] sel, cand, gidx, rr_nxt;
   logic             found;
   logic             g_awv, g_wv, g_br, g_arv, g_rr;
   logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign req = s_awvalid | s_arvalid;

   // First requester at or after the rr pointer, wrapping modulo NUM_M.
   always_comb begin
      int idx;
      idx   = 0;
      cand  = '0;
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NUM_M; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_M) idx = idx - NUM_M;
         cand = PTR_W'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_M; i++)
         if (grant_q[i]) gidx = PTR_W'(i);
   end

   assign rr_nxt = (gidx == PTR_W'(NUM_M - 1)) ? '0 : gidx + PTR_W'(1);

   // Address/data mux; everything stays 0 while nobody holds the grant.
   always_comb begin
      m_awaddr = '0;
      m_wdata  = '0;
      m_wstrb  = '0;
      m_araddr = '0;
      g_awv    = 1'b0;
      g_wv     = 1'b0;
      g_br     = 1'b0;
      g_arv    = 1'b0;
      g_rr     = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         if (grant_q[i]) begin
            m_awaddr = s_awaddr[i*ADDR_W +: ADDR_W];
            m_wdata  = s_wdata[i*DATA_W +: DATA_W];
            m_wstrb  = s_wstrb[i*STRB_W +: STRB_W];
            m_araddr = s_araddr[i*ADDR_W +: ADDR_W];
            g_awv    = s_awvalid[i];
            g_wv     = s_wvalid[i];
            g_br     = s_bready[i];
            g_arv    = s_arvalid[i];
            g_rr     = s_rready[i];
         end
      end
   end

   // A completed AW or W channel is masked so the slave sees exactly one write.
   assign m_awvalid = (state_q == WADDR) && !aw_done_q && g_awv;
   assign m_wvalid  = (state_q == WADDR) && !w_done_q && g_wv;
   assign m_bready  = (state_q == WRESP) && g_br;
   assign m_arvalid = (state_q == RADDR) && g_arv;
   assign m_rready  = (state_q == RRESP) && g_rr;

   assign s_awready = grant_q & {NUM_M{(state_q == WADDR) && !aw_done_q && m_awready}};
   assign s_wready  = grant_q & {NUM_M{(state_q == WADDR) && !w_done_q && m_wready}};
   assign s_bvalid  = grant_q & {NUM_M{(state_q == WRESP) && m_bvalid}};
   assign s_arready = grant_q & {NUM_M{(state_q == RADDR) && m_arready}};
   assign s_rvalid  = grant_q & {NUM_M{(state_q == RRESP) && m_rvalid}};
   assign s_rdata   = m_rdata;

   assign aw_hs = m_awvalid && m_awready;
   assign w_hs  = m_wvalid && m_wready;
   assign b_hs  = m_bvalid && m_bready;
   assign ar_hs = m_arvalid && m_arready;
   assign r_hs  = m_rvalid && m_rready;

   assign grant = grant_q;
   assign busy  = (state_q != IDLE);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: if (found) begin
            grant_d      = '0;
            grant_d[sel] = 1'b1;
            state_d      = s_awvalid[sel] ? WADDR : RADDR;
            aw_done_d    = 1'b0;
            w_done_d     = 1'b0;
         end
         WADDR: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d && w_done_d) state_d = WRESP;
         end
         WRESP: if (b_hs) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = rr_nxt;
         end
         RADDR: if (ar_hs) state_d = RRESP;
         RRESP: if (r_hs) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = rr_nxt;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_q      <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

`ifdef AXI_ARB_STATS_EN
   logic [NUM_M-1:0][15:0] cnt_q;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)            cnt_q <= '0;
      else if (b_hs || r_hs) cnt_q[gidx] <= cnt_q[gidx] + 16'd1;
   end

   assign txn_count = cnt_q;
`endif

endmodule

// File: tb/tb_axi_light_arbiter.sv
// Bench for axi_light_arbiter: directed scenarios plus randomized requests checked
// against a round-robin reference model (pending requests, rr pointer, per-master counts).
module tb_axi_light_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic clk, res_n;
   logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
   logic [N*AW-1:0] s_awaddr, s_araddr;
   logic [N*DW-1:0] s_wdata;
   logic [N*SW-1:0] s_wstrb;
   logic [DW-1:0]   s_rdata;
   logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic            m_arvalid, m_arready, m_rvalid, m_rready;
   logic [AW-1:0]   m_awaddr, m_araddr;
   logic [DW-1:0]   m_wdata, m_rdata;
   logic [SW-1:0]   m_wstrb;
   logic [N-1:0]    grant;
   logic            busy;
`ifdef AXI_ARB_STATS_EN
   logic [N*16-1:0] txn_count;
`endif

   int checks = 0;
   int failures = 0;
   int rr_m;
   int txn_m [N];
   int aw_hs_n = 0;
   int w_hs_n = 0;

   axi_light_arbiter #(.NUM_M(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .res_n(res_n),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .grant(grant),
`ifdef AXI_ARB_STATS_EN
      .txn_count(txn_count),
`endif
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (res_n && m_awvalid && m_awready) aw_hs_n <= aw_hs_n + 1;
      if (res_n && m_wvalid && m_wready)   w_hs_n  <= w_hs_n + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference arbitration rule: first requester at or after the pointer.
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return 0;
   endfunction

   task automatic model_reset();
      rr_m = 0;
      for (int i = 0; i < N; i++) txn_m[i] = 0;
   endtask

   task automatic do_reset();
      res_n = 1'b0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      res_n = 1'b1;
      tick();
      model_reset();
   endtask

   // Runs one full transaction for master g with random slave-side latency.
   task automatic serve(input int g);
      logic [N-1:0]  gm;
      logic          is_w, aw_p, w_p, ar_p, aw_h, w_h, ar_h;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed, rd;
      logic [SW-1:0] es;
      int            n, bd;
      gm = '0;
      gm[g] = 1'b1;
      is_w = s_awvalid[g];
      m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
      #1;
      chk("idle_awready", s_awready, 0);
      chk("idle_wready", s_wready, 0);
      chk("idle_arready", s_arready, 0);
      chk("idle_busy", busy, 0);
      tick();
      chk("grant", grant, gm);
      chk("busy", busy, 1);
      if (is_w) begin
         ea = s_awaddr[g*AW +: AW];
         ed = s_wdata[g*DW +: DW];
         es = s_wstrb[g*SW +: SW];
         aw_p = 1'b1;
         w_p  = s_wvalid[g];
         n = 0;
         while ((aw_p || w_p) && n < 64) begin
            m_awready = ($urandom_range(0, 2) != 0);
            m_wready  = ($urandom_range(0, 2) != 0);
            #1;
            chk("m_awvalid", m_awvalid, aw_p);
            chk("m_wvalid", m_wvalid, w_p);
            if (aw_p) chk("m_awaddr", m_awaddr, ea);
            if (w_p) begin
               chk("m_wdata", m_wdata, ed);
               chk("m_wstrb", m_wstrb, es);
            end
            chk("s_awready", s_awready, (aw_p && m_awready) ? gm : '0);
            chk("s_wready", s_wready, (w_p && m_wready) ? gm : '0);
            aw_h = aw_p && m_awready;
            w_h  = w_p && m_wready;
            tick();
            n++;
            if (aw_h) begin aw_p = 1'b0; s_awvalid[g] = 1'b0; end
            if (w_h)  begin w_p = 1'b0;  s_wvalid[g] = 1'b0;  end
         end
         chk("waddr_done", {aw_p, w_p}, 0);
         m_awready = 1'b0; m_wready = 1'b0;
         bd = $urandom_range(0, 3);
         for (int j = 0; j < bd; j++) begin
            chk("wresp_wait_bvalid", s_bvalid, 0);
            chk("wresp_awvalid", m_awvalid, 0);
            chk("wresp_wvalid", m_wvalid, 0);
            chk("wresp_grant", grant, gm);
            tick();
         end
         m_bvalid = 1'b1;
         #1;
         chk("s_bvalid", s_bvalid, gm);
         chk("m_bready", m_bready, 1);
         tick();
         m_bvalid = 1'b0;
      end else begin
         ea = s_araddr[g*AW +: AW];
         ar_p = 1'b1;
         n = 0;
         while (ar_p && n < 64) begin
            m_arready = ($urandom_range(0, 2) != 0);
            #1;
            chk("m_arvalid", m_arvalid, 1);
            chk("m_araddr", m_araddr, ea);
            chk("s_arready", s_arready, m_arready ? gm : '0);
            ar_h = m_arready;
            tick();
            n++;
            if (ar_h) begin ar_p = 1'b0; s_arvalid[g] = 1'b0; end
         end
         chk("raddr_done", ar_p, 0);
         m_arready = 1'b0;
         bd = $urandom_range(0, 3);
         for (int j = 0; j < bd; j++) begin
            chk("rresp_wait_rvalid", s_rvalid, 0);
            chk("rresp_arvalid", m_arvalid, 0);
            tick();
         end
         rd = $urandom;
         m_rdata  = rd;
         m_rvalid = 1'b1;
         #1;
         chk("s_rvalid", s_rvalid, gm);
         chk("s_rdata", s_rdata, rd);
         chk("m_rready", m_rready, 1);
         tick();
         m_rvalid = 1'b0;
      end
      chk("post_grant", grant, 0);
      chk("post_busy", busy, 0);
      rr_m = (g + 1) % N;
      txn_m[g]++;
   endtask

   task automatic req_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      s_awvalid[m] = 1'b1;
      s_wvalid[m]  = 1'b1;
      s_awaddr[m*AW +: AW] = a;
      s_wdata[m*DW +: DW]  = d;
      s_wstrb[m*SW +: SW]  = s;
   endtask

   task automatic req_read(input int m, input logic [AW-1:0] a);
      s_arvalid[m] = 1'b1;
      s_araddr[m*AW +: AW] = a;
   endtask

   int g, prev, aw0, w0, n;

   initial begin
      res_n = 1'b0;
      s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
      s_bready = '1; s_rready = '1;
      s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      model_reset();

      // reset state
      #12;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
      chk("rst_s_readies", {s_awready, s_wready, s_arready}, 0);
      chk("rst_s_resp", {s_bvalid, s_rvalid}, 0);
      chk("rst_m_addr", {m_awaddr, m_araddr}, 0);
      @(negedge clk);
      res_n = 1'b1;
      tick();

      // single write from master0
      req_write(0, 32'h0000_1000, 32'hCAFE_BABE, 4'hF);
      serve(pick(s_awvalid | s_arvalid, rr_m));

      // contention straight after reset: master0 first, then master1
      do_reset();
      req_read(0, 32'h100);
      req_read(1, 32'h200);
      g = pick(s_awvalid | s_arvalid, rr_m);
      chk("cont_first", g, 0);
      serve(g);
      g = pick(s_awvalid | s_arvalid, rr_m);
      chk("cont_second", g, 1);
      serve(g);

      // continuous reads from both masters must alternate
      req_read(0, 32'h400);
      req_read(1, 32'h500);
      prev = -1;
      for (int i = 0; i < 8; i++) begin
         g = pick(s_awvalid | s_arvalid, rr_m);
         chk("rr_alternate", g, i % 2);
         chk("rr_no_repeat", (g == prev), 0);
         prev = g;
         serve(g);
         if (i < 6) req_read(g, 32'h400 + 32'(i * 16));
      end

      // W three cycles ahead of AW: no grant until AW, then exactly one write
      s_wvalid[0] = 1'b1;
      s_wdata[0*DW +: DW] = 32'h1234_5678;
      s_wstrb[0*SW +: SW] = 4'h3;
      m_wready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ooo_idle_busy", busy, 0);
         chk("ooo_idle_wready", s_wready, 0);
         tick();
      end
      req_write(0, 32'h0000_2000, 32'h1234_5678, 4'h3);
      aw0 = aw_hs_n;
      w0  = w_hs_n;
      serve(pick(s_awvalid | s_arvalid, rr_m));
      chk("ooo_aw_count", aw_hs_n - aw0, 1);
      chk("ooo_w_count", w_hs_n - w0, 1);

      // B backpressure on master1 while master0 waits with a read
      req_write(1, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF);
      g = pick(s_awvalid | s_arvalid, rr_m);
      chk("bp_pick", g, 1);
      tick();
      chk("bp_grant", grant, 2'b10);
      req_read(0, 32'h0000_0600);
      m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
      tick();
      s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0;
      m_bvalid = 1'b1;
      s_bready[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_grant_hold", grant, 2'b10);
         chk("bp_arready", s_arready, 0);
         chk("bp_bvalid", s_bvalid, 2'b10);
         chk("bp_m_bready", m_bready, 0);
         tick();
      end
      s_bready[1] = 1'b1;
      #1;
      chk("bp_m_bready_rel", m_bready, 1);
      tick();
      m_bvalid = 1'b0;
      chk("bp_post_grant", grant, 0);
      rr_m = 0;
      txn_m[1]++;
      g = pick(s_awvalid | s_arvalid, rr_m);
      chk("bp_next", g, 0);
      serve(g);

      // randomized requests against the round-robin model
      for (int it = 0; it < 40; it++) begin
         for (int m = 0; m < N; m++) begin
            if (!s_awvalid[m] && !s_arvalid[m] && $urandom_range(0, 1) == 1) begin
               n = $urandom_range(0, 2);
               if (n != 1) req_write(m, $urandom, $urandom, SW'($urandom));
               if (n != 0) req_read(m, $urandom);
            end
         end
         if ((s_awvalid | s_arvalid) != '0) serve(pick(s_awvalid | s_arvalid, rr_m));
      end
      n = 0;
      while ((s_awvalid | s_arvalid) != '0 && n < 8) begin
         serve(pick(s_awvalid | s_arvalid, rr_m));
         n++;
      end
      chk("rand_drained", s_awvalid | s_arvalid, 0);
`ifdef AXI_ARB_STATS_EN
      for (int m = 0; m < N; m++) chk("txn_count", txn_count[m*16 +: 16], 16'(txn_m[m]));
`endif

      // reset in the middle of a read response
      req_read(0, 32'h0000_0700);
      tick();
      m_arready = 1'b1;
      tick();
      s_arvalid[0] = 1'b0;
      m_arready = 1'b0;
      s_rready[0] = 1'b0;
      m_rvalid = 1'b1;
      #1;
      chk("mid_rvalid", s_rvalid, 2'b01);
      chk("mid_busy", busy, 1);
      #2;
      res_n = 1'b0;
      #1;
      chk("arst_grant", grant, 0);
      chk("arst_busy", busy, 0);
      chk("arst_rvalid", s_rvalid, 0);
      chk("arst_m_rready", m_rready, 0);
      chk("arst_m_araddr", m_araddr, 0);
`ifdef AXI_ARB_STATS_EN
      chk("arst_txn_count", txn_count, 0);
`endif
      @(negedge clk);
      m_rvalid = 1'b0;
      s_rready = '1;
      res_n = 1'b1;
      model_reset();
      tick();
      chk("arst_idle", busy, 0);
      req_read(0, 32'h0000_0800);
      req_read(1, 32'h0000_0900);
      g = pick(s_awvalid | s_arvalid, rr_m);
      chk("arst_rr_restart", g, 0);
      serve(g);
      serve(pick(s_awvalid | s_arvalid, rr_m));
`ifdef AXI_ARB_STATS_EN
      for (int m = 0; m < N; m++) chk("txn_count_after", txn_count[m*16 +: 16], 16'(txn_m[m]));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
